// File: rtl/dbg_hart_array.sv
// Debug-module hart array: one halt/resume/step handshake FSM per hart with
// handshake timeout, plus a shared register-access port into halted harts.
module dbg_hart_array #(
  parameter int NUM_HARTS = 4,
  parameter int TMO_W     = 8,
  parameter int HSEL_W    = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NUM_HARTS-1:0]    sel_mask_i,
  input  logic                    halt_cmd_i,
  input  logic                    resume_cmd_i,
  input  logic                    step_cmd_i,
  input  logic [HSEL_W-1:0]       hartsel_i,
  input  logic                    acc_req_i,
  input  logic                    acc_wr_i,
  input  logic [15:0]             acc_addr_i,
  input  logic [31:0]             acc_wdata_i,
  output logic [31:0]             acc_rdata_o,
  output logic                    acc_done_o,
  output logic                    acc_err_o,
  output logic                    busy_o,
  output logic [NUM_HARTS-1:0]    halted_o,
  output logic [NUM_HARTS-1:0]    ebreak_cause_o,
  output logic [NUM_HARTS-1:0]    tmo_err_o,
  output logic                    any_halted_o,
  output logic                    all_halted_o,
  output logic [NUM_HARTS-1:0]    core_halt_req_o,
  input  logic [NUM_HARTS-1:0]    core_halt_ack_i,
  input  logic [NUM_HARTS-1:0]    core_resume_ack_i,
  input  logic [NUM_HARTS-1:0]    core_ebreak_i,
  input  logic [NUM_HARTS-1:0]    core_step_exec_i,
  output logic [NUM_HARTS-1:0]    core_reg_en_o,
  output logic                    core_reg_wr_o,
  output logic [15:0]             core_reg_addr_o,
  output logic [31:0]             core_reg_wdata_o,
  input  logic [32*NUM_HARTS-1:0] core_reg_rdata_i
);

  typedef enum logic [2:0] {
    RUNNING  = 3'd0,
    HALTING  = 3'd1,
    HALTED   = 3'd2,
    RESUMING = 3'd3,
    STEPPING = 3'd4
  } hart_state_t;

  typedef enum logic [1:0] {
    A_IDLE    = 2'd0,
    A_STROBE  = 2'd1,
    A_CAPTURE = 2'd2
  } acc_state_t;

  logic [NUM_HARTS-1:0] w_halted_vec;
  logic [NUM_HARTS-1:0] w_halted_nxt_vec;
  logic [NUM_HARTS-1:0] w_halt_req_vec;
  logic [NUM_HARTS-1:0] w_eb_vec;
  logic [NUM_HARTS-1:0] w_tmo_vec;
  logic [NUM_HARTS-1:0] w_acc_lock;

  acc_state_t           r_acc_state;
  acc_state_t           w_acc_state_nxt;
  logic [NUM_HARTS-1:0] w_sel_onehot;
  logic [NUM_HARTS-1:0] r_acc_onehot;
  logic [NUM_HARTS-1:0] r_reg_en;
  logic                 w_sel_halted;
  logic                 w_acc_idle;
  logic                 w_acc_accept;
  logic                 w_acc_reject;
  logic [31:0]          w_cap_rdata;
  logic                 r_reg_wr;
  logic [15:0]          r_reg_addr;
  logic [31:0]          r_reg_wdata;
  logic [31:0]          r_rdata;
  logic                 r_done;
  logic                 r_err;
  logic                 r_busy;
  logic                 r_any;
  logic                 r_all;

  // Out-of-range hartsel decodes to an all-zero one-hot and is rejected.
  always_comb begin
    w_sel_onehot = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      w_sel_onehot[h] = (hartsel_i == HSEL_W'(h));
    end
  end

  assign w_sel_halted = |(w_sel_onehot & w_halted_vec);
  assign w_acc_idle   = (r_acc_state == A_IDLE);
  assign w_acc_accept = w_acc_idle & acc_req_i & w_sel_halted;
  assign w_acc_reject = w_acc_idle & acc_req_i & ~w_sel_halted;
  // A hart is locked from resume/step while its access is being accepted or in flight.
  assign w_acc_lock   = w_acc_idle ? (w_acc_accept ? w_sel_onehot : '0) : r_acc_onehot;

  always_comb begin
    w_acc_state_nxt = r_acc_state;
    case (r_acc_state)
      A_IDLE: begin
        if (w_acc_accept) begin
          w_acc_state_nxt = A_STROBE;
        end else begin
          w_acc_state_nxt = A_IDLE;
        end
      end
      A_STROBE:  w_acc_state_nxt = A_CAPTURE;
      A_CAPTURE: w_acc_state_nxt = A_IDLE;
      default:   w_acc_state_nxt = A_IDLE;
    endcase
  end

  always_comb begin
    w_cap_rdata = 32'h0000_0000;
    for (int h = 0; h < NUM_HARTS; h++) begin
      w_cap_rdata = w_cap_rdata | (core_reg_rdata_i[32*h +: 32] & {32{r_acc_onehot[h]}});
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_acc_state  <= A_IDLE;
      r_acc_onehot <= '0;
      r_reg_en     <= '0;
      r_reg_wr     <= 1'b0;
      r_reg_addr   <= 16'h0000;
      r_reg_wdata  <= 32'h0000_0000;
      r_rdata      <= 32'h0000_0000;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_acc_state <= w_acc_state_nxt;
      r_busy      <= (w_acc_state_nxt != A_IDLE);
      r_reg_en    <= (w_acc_state_nxt == A_STROBE) ? w_sel_onehot : '0;
      if (w_acc_accept) begin
        r_acc_onehot <= w_sel_onehot;
        r_reg_wr     <= acc_wr_i;
        r_reg_addr   <= acc_addr_i;
        r_reg_wdata  <= acc_wdata_i;
      end else begin
        r_acc_onehot <= r_acc_onehot;
      end
      r_done <= w_acc_reject | (r_acc_state == A_CAPTURE);
      r_err  <= w_acc_reject;
      if ((r_acc_state == A_CAPTURE) && !r_reg_wr) begin
        r_rdata <= w_cap_rdata;
      end else begin
        r_rdata <= r_rdata;
      end
    end
  end

  for (genvar g = 0; g < NUM_HARTS; g++) begin : g_hart
    localparam logic [TMO_W-1:0] CntLast = '1;

    hart_state_t      r_state;
    hart_state_t      w_state_nxt;
    logic [TMO_W-1:0] r_cnt;
    logic [TMO_W-1:0] w_cnt_inc;
    logic             w_tmo;
    logic             w_res_req;
    logic             w_step_req;
    logic             w_set_eb;
    logic             w_clr_eb;
    logic             w_set_tmo;
    logic             r_pend_res;
    logic             r_pend_step;
    logic             r_halted;
    logic             r_halt_req;
    logic             r_eb;
    logic             r_tmo;

    assign w_cnt_inc  = r_cnt + TMO_W'(1'b1);
    assign w_tmo      = (w_cnt_inc == CntLast);
    assign w_res_req  = (resume_cmd_i & sel_mask_i[g]) | r_pend_res;
    assign w_step_req = (step_cmd_i & sel_mask_i[g]) | r_pend_step;

    always_comb begin
      w_state_nxt = r_state;
      w_set_eb    = 1'b0;
      w_clr_eb    = 1'b0;
      w_set_tmo   = 1'b0;
      case (r_state)
        RUNNING: begin
          if (core_ebreak_i[g]) begin
            w_state_nxt = HALTING;
            w_set_eb    = 1'b1;
          end else if (halt_cmd_i && sel_mask_i[g]) begin
            w_state_nxt = HALTING;
          end else begin
            w_state_nxt = RUNNING;
          end
        end
        HALTING: begin
          if (core_halt_ack_i[g]) begin
            w_state_nxt = HALTED;
          end else if (w_tmo) begin
            w_state_nxt = RUNNING;
            w_set_tmo   = 1'b1;
          end else begin
            w_state_nxt = HALTING;
          end
        end
        HALTED: begin
          if (w_acc_lock[g]) begin
            w_state_nxt = HALTED;
          end else if (w_res_req) begin
            w_state_nxt = RESUMING;
          end else if (w_step_req) begin
            w_state_nxt = STEPPING;
          end else begin
            w_state_nxt = HALTED;
          end
        end
        RESUMING: begin
          if (core_resume_ack_i[g]) begin
            w_state_nxt = RUNNING;
            w_clr_eb    = 1'b1;
          end else if (w_tmo) begin
            w_state_nxt = HALTED;
            w_set_tmo   = 1'b1;
          end else begin
            w_state_nxt = RESUMING;
          end
        end
        STEPPING: begin
          if (core_step_exec_i[g]) begin
            w_state_nxt = HALTED;
          end else if (w_tmo) begin
            w_state_nxt = HALTED;
            w_set_tmo   = 1'b1;
          end else begin
            w_state_nxt = STEPPING;
          end
        end
        default: w_state_nxt = RUNNING;
      endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        r_state     <= RUNNING;
        r_cnt       <= '0;
        r_pend_res  <= 1'b0;
        r_pend_step <= 1'b0;
        r_halted    <= 1'b0;
        r_halt_req  <= 1'b0;
        r_eb        <= 1'b0;
        r_tmo       <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        if ((w_state_nxt != r_state) || (r_state == RUNNING) || (r_state == HALTED)) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= w_cnt_inc;
        end
        r_pend_res  <= (r_state == HALTED) & w_acc_lock[g] & w_res_req;
        r_pend_step <= (r_state == HALTED) & w_acc_lock[g] & w_step_req & ~w_res_req;
        r_halted    <= (w_state_nxt == HALTED);
        r_halt_req  <= (w_state_nxt == HALTING) | (w_state_nxt == HALTED);
        r_eb        <= (r_eb | w_set_eb) & ~w_clr_eb;
        r_tmo       <= r_tmo | w_set_tmo;
      end
    end

    assign w_halted_vec[g]     = r_halted;
    assign w_halted_nxt_vec[g] = (w_state_nxt == HALTED);
    assign w_halt_req_vec[g]   = r_halt_req;
    assign w_eb_vec[g]         = r_eb;
    assign w_tmo_vec[g]        = r_tmo;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_any <= 1'b0;
      r_all <= 1'b0;
    end else begin
      r_any <= |w_halted_nxt_vec;
      r_all <= &w_halted_nxt_vec;
    end
  end

  assign acc_rdata_o      = r_rdata;
  assign acc_done_o       = r_done;
  assign acc_err_o        = r_err;
  assign busy_o           = r_busy;
  assign halted_o         = w_halted_vec;
  assign ebreak_cause_o   = w_eb_vec;
  assign tmo_err_o        = w_tmo_vec;
  assign any_halted_o     = r_any;
  assign all_halted_o     = r_all;
  assign core_halt_req_o  = w_halt_req_vec;
  assign core_reg_en_o    = r_reg_en;
  assign core_reg_wr_o    = r_reg_wr;
  assign core_reg_addr_o  = r_reg_addr;
  assign core_reg_wdata_o = r_reg_wdata;

endmodule
